// File: rtl/uart_loopback_cfg.sv
// Configurable UART transmitter/receiver pair with selectable frame format,
// runtime internal/external loopback and receive parity/framing error flags.
module uart_loopback_cfg #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 loopback_i,
    input  logic                 tx_start_i,
    input  logic [DATA_BITS-1:0] tx_byte_i,
    output logic                 tx_active_o,
    output logic                 tx_done_o,
    output logic                 tx_serial_o,
    input  logic                 rx_serial_i,
    output logic                 data_valid_o,
    output logic [DATA_BITS-1:0] rx_byte_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o
);
    localparam int TW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(DATA_BITS);
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          HAS_PAR   = (PARITY_EN != 0);
    localparam logic          ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rx_state_e;

    tx_state_e            tx_state_q, tx_state_d;
    logic [TW-1:0]        tx_timer_q, tx_timer_d;
    logic [IW-1:0]        tx_idx_q, tx_idx_d;
    logic                 tx_stop_q, tx_stop_d;
    logic [DATA_BITS-1:0] tx_byte_q, tx_byte_d;
    logic                 tx_serial_q, tx_serial_d;
    logic                 tx_par;

    rx_state_e            rx_state_q, rx_state_d;
    logic [TW-1:0]        rx_timer_q, rx_timer_d;
    logic [IW-1:0]        rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 data_valid_q, data_valid_d;
    logic [1:0]           sync_q;
    logic                 rx_src, rx_bit;

    assign tx_par = (^tx_byte_q) ^ ODD;

    // Serial output is registered from the next state so the pin never glitches.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_timer_d  = tx_timer_q;
        tx_idx_d    = tx_idx_q;
        tx_stop_d   = tx_stop_q;
        tx_byte_d   = tx_byte_q;
        tx_serial_d = tx_serial_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_serial_d = 1'b1;
                if (tx_start_i) begin
                    tx_byte_d   = tx_byte_i;
                    tx_timer_d  = '0;
                    tx_serial_d = 1'b0;
                    tx_state_d  = TX_START;
                end
            end
            TX_START: begin
                if (tx_timer_q == BIT_LAST) begin
                    tx_timer_d  = '0;
                    tx_idx_d    = '0;
                    tx_serial_d = tx_byte_q[0];
                    tx_state_d  = TX_DATA;
                end else begin
                    tx_timer_d = tx_timer_q + TW'(1);
                end
            end
            TX_DATA: begin
                if (tx_timer_q == BIT_LAST) begin
                    tx_timer_d = '0;
                    if (tx_idx_q == IDX_LAST) begin
                        tx_stop_d = 1'b0;
                        if (HAS_PAR) begin
                            tx_serial_d = tx_par;
                            tx_state_d  = TX_PARITY;
                        end else begin
                            tx_serial_d = 1'b1;
                            tx_state_d  = TX_STOP;
                        end
                    end else begin
                        tx_idx_d    = tx_idx_q + IW'(1);
                        tx_serial_d = tx_byte_q[tx_idx_d];
                    end
                end else begin
                    tx_timer_d = tx_timer_q + TW'(1);
                end
            end
            TX_PARITY: begin
                if (tx_timer_q == BIT_LAST) begin
                    tx_timer_d  = '0;
                    tx_stop_d   = 1'b0;
                    tx_serial_d = 1'b1;
                    tx_state_d  = TX_STOP;
                end else begin
                    tx_timer_d = tx_timer_q + TW'(1);
                end
            end
            TX_STOP: begin
                tx_serial_d = 1'b1;
                if (tx_timer_q == BIT_LAST) begin
                    tx_timer_d = '0;
                    if (tx_stop_q == STOP_LAST) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_stop_d = 1'b1;
                    end
                end else begin
                    tx_timer_d = tx_timer_q + TW'(1);
                end
            end
            default: begin
                tx_serial_d = 1'b1;
                tx_state_d  = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_state_q  <= TX_IDLE;
            tx_timer_q  <= '0;
            tx_idx_q    <= '0;
            tx_stop_q   <= 1'b0;
            tx_byte_q   <= '0;
            tx_serial_q <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_timer_q  <= tx_timer_d;
            tx_idx_q    <= tx_idx_d;
            tx_stop_q   <= tx_stop_d;
            tx_byte_q   <= tx_byte_d;
            tx_serial_q <= tx_serial_d;
        end
    end

    assign tx_active_o = (tx_state_q != TX_IDLE);
    assign tx_done_o   = (tx_state_q == TX_STOP) && (tx_timer_q == BIT_LAST) && (tx_stop_q == STOP_LAST);
    assign tx_serial_o = tx_serial_q;

    // Receiver input source, then a 2-flop synchroniser that idles high.
    assign rx_src = loopback_i ? tx_serial_q : rx_serial_i;
    assign rx_bit = sync_q[1];

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_timer_d   = rx_timer_q;
        rx_idx_d     = rx_idx_q;
        rx_shift_d   = rx_shift_q;
        rx_par_d     = rx_par_q;
        rx_byte_d    = rx_byte_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        data_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_bit) begin
                    rx_timer_d = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // A start bit that is gone by mid-bit is treated as a glitch.
                if (rx_timer_q == HALF_LAST) begin
                    rx_timer_d = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_bit ? RX_IDLE : RX_DATA;
                end else begin
                    rx_timer_d = rx_timer_q + TW'(1);
                end
            end
            RX_DATA: begin
                if (rx_timer_q == BIT_LAST) begin
                    rx_timer_d = '0;
                    rx_shift_d = {rx_bit, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == IDX_LAST) begin
                        rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + IW'(1);
                    end
                end else begin
                    rx_timer_d = rx_timer_q + TW'(1);
                end
            end
            RX_PARITY: begin
                if (rx_timer_q == BIT_LAST) begin
                    rx_timer_d = '0;
                    rx_par_d   = rx_bit;
                    rx_state_d = RX_STOP;
                end else begin
                    rx_timer_d = rx_timer_q + TW'(1);
                end
            end
            RX_STOP: begin
                if (rx_timer_q == BIT_LAST) begin
                    rx_timer_d   = '0;
                    data_valid_d = 1'b1;
                    rx_byte_d    = rx_shift_q;
                    parity_err_d = HAS_PAR & ((^rx_shift_q) ^ ODD ^ rx_par_q);
                    frame_err_d  = ~rx_bit;
                    rx_state_d   = rx_bit ? RX_IDLE : RX_WAIT_IDLE;
                end else begin
                    rx_timer_d = rx_timer_q + TW'(1);
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_bit) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q       <= 2'b11;
            rx_state_q   <= RX_IDLE;
            rx_timer_q   <= '0;
            rx_idx_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_q     <= 1'b0;
            rx_byte_q    <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx_src};
            rx_state_q   <= rx_state_d;
            rx_timer_q   <= rx_timer_d;
            rx_idx_q     <= rx_idx_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_q     <= rx_par_d;
            rx_byte_q    <= rx_byte_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_valid_o = data_valid_q;
    assign rx_byte_o    = rx_byte_q;
    assign parity_err_o = parity_err_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_uart_loopback_cfg.sv
// Scoreboard bench for uart_loopback_cfg: three instances (8N1, 7O2, 8E1) at 16 clocks per bit.
module tb_uart_loopback_cfg;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic l0 = 1'b1, s0 = 1'b0, r0 = 1'b1;
    logic [7:0] b0 = 8'h00;
    logic ta0, td0, ts0, dv0, pe0, fe0;
    logic [7:0] rb0;

    logic l1 = 1'b1, s1 = 1'b0, r1 = 1'b1;
    logic [6:0] b1 = 7'h00;
    logic ta1, td1, ts1, dv1, pe1, fe1;
    logic [6:0] rb1;

    logic l2 = 1'b0, s2 = 1'b0, r2 = 1'b1;
    logic [7:0] b2 = 8'h00;
    logic ta2, td2, ts2, dv2, pe2, fe2;
    logic [7:0] rb2;

    uart_loopback_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .loopback_i(l0), .tx_start_i(s0), .tx_byte_i(b0),
        .tx_active_o(ta0), .tx_done_o(td0), .tx_serial_o(ts0), .rx_serial_i(r0),
        .data_valid_o(dv0), .rx_byte_o(rb0), .parity_err_o(pe0), .frame_err_o(fe0));

    uart_loopback_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .loopback_i(l1), .tx_start_i(s1), .tx_byte_i(b1),
        .tx_active_o(ta1), .tx_done_o(td1), .tx_serial_o(ts1), .rx_serial_i(r1),
        .data_valid_o(dv1), .rx_byte_o(rb1), .parity_err_o(pe1), .frame_err_o(fe1));

    uart_loopback_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .loopback_i(l2), .tx_start_i(s2), .tx_byte_i(b2),
        .tx_active_o(ta2), .tx_done_o(td2), .tx_serial_o(ts2), .rx_serial_i(r2),
        .data_valid_o(dv2), .rx_byte_o(rb2), .parity_err_o(pe2), .frame_err_o(fe2));

    typedef struct {
        int         dut;
        logic [7:0] b;
        logic       pe;
        logic       fe;
        int         cyc;
    } rx_exp_t;

    typedef struct {
        int dut;
        int cyc;
    } done_exp_t;

    rx_exp_t   rx_q[$];
    done_exp_t done_q[$];

    int cyc = 0;
    int t0 = 0;
    int n_vec = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Relative cycle number of the value visible now (cycle 0 = accepting edge).
    function automatic int rel_now();
        return cyc + 1 - t0;
    endfunction

    task automatic exp_rx(input int d, input logic [7:0] b, input logic pe, input logic fe, input int c);
        rx_exp_t e;
        e.dut = d; e.b = b; e.pe = pe; e.fe = fe; e.cyc = c;
        rx_q.push_back(e);
    endtask

    task automatic exp_done(input int d, input int c);
        done_exp_t e;
        e.dut = d; e.cyc = c;
        done_q.push_back(e);
    endtask

    task automatic check_rx(input int d, input logic [7:0] b, input logic pe, input logic fe);
        rx_exp_t e;
        int rel;
        rel = rel_now();
        n_vec++;
        if (rx_q.size() == 0) begin
            n_err++;
            $display("FAIL rx_unexpected dut=%0d got byte=%02h perr=%0b ferr=%0b rel=%0d, required no Data_Valid",
                     d, b, pe, fe, rel);
        end else begin
            e = rx_q.pop_front();
            if (e.dut != d || e.b != b || e.pe != pe || e.fe != fe || (e.cyc >= 0 && e.cyc != rel)) begin
                n_err++;
                $display("FAIL rx_frame got dut=%0d byte=%02h perr=%0b ferr=%0b rel=%0d, required dut=%0d byte=%02h perr=%0b ferr=%0b rel=%0d",
                         d, b, pe, fe, rel, e.dut, e.b, e.pe, e.fe, e.cyc);
            end else begin
                $display("rx   dut=%0d byte=%02h perr=%0b ferr=%0b rel=%0d ok", d, b, pe, fe, rel);
            end
        end
    endtask

    task automatic check_done(input int d);
        done_exp_t e;
        int rel;
        rel = rel_now();
        n_vec++;
        if (done_q.size() == 0) begin
            n_err++;
            $display("FAIL tx_done_unexpected dut=%0d rel=%0d, required no Tx_Done", d, rel);
        end else begin
            e = done_q.pop_front();
            if (e.dut != d || e.cyc != rel) begin
                n_err++;
                $display("FAIL tx_done got dut=%0d rel=%0d, required dut=%0d rel=%0d", d, rel, e.dut, e.cyc);
            end else begin
                $display("done dut=%0d rel=%0d ok", d, rel);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever any instance presents an output event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dv0) check_rx(0, rb0, pe0, fe0);
            if (dv1) check_rx(1, {1'b0, rb1}, pe1, fe1);
            if (dv2) check_rx(2, rb2, pe2, fe2);
            if (td0) check_done(0);
            if (td1) check_done(1);
            if (td2) check_done(2);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s got %0h required %0h", nm, got, req);
        end else begin
            $display("chk  %s = %0h ok", nm, got);
        end
    endtask

    task automatic wait_rel(input int n);
        while (rel_now() < n) @(negedge clk);
    endtask

    task automatic pulse_start(input int d, input logic [7:0] b);
        if (d == 0) begin
            b0 = b; s0 = 1'b1;
        end else begin
            b1 = b[6:0]; s1 = 1'b1;
        end
        t0 = cyc + 1;
        @(negedge clk);
        s0 = 1'b0;
        s1 = 1'b0;
    endtask

    task automatic send_serial(input int d, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (d == 0) r0 = bits[i];
            else        r2 = bits[i];
            repeat (CPB) @(negedge clk);
        end
        r0 = 1'b1;
        r2 = 1'b1;
    endtask

    logic [9:0] pat_a5;

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset tx_serial0", ts0, 1);
        chk("reset tx_active0", ta0, 0);
        chk("reset tx_done0", td0, 0);
        chk("reset data_valid0", dv0, 0);
        chk("reset rx_byte0", rb0, 0);
        chk("reset frame_err0", fe0, 0);
        chk("reset parity_err2", pe2, 0);
        chk("reset tx_serial1", ts1, 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1 loopback of 0xA5: start, data LSB first, stop.
        l0 = 1'b1;
        pat_a5 = 10'b1101001010;
        exp_rx(0, 8'hA5, 1'b0, 1'b0, 155);
        exp_done(0, 160);
        pulse_start(0, 8'hA5);
        chk("t1 tx_active rel2", ta0, 1);
        for (int k = 0; k < 10; k++) begin
            wait_rel(1 + k * CPB + CPB / 2);
            chk($sformatf("t1 serial bit%0d", k), ts0, pat_a5[k]);
        end
        wait_rel(160);
        chk("t1 tx_active rel160", ta0, 1);
        wait_rel(161);
        chk("t1 tx_active rel161", ta0, 0);
        chk("t1 serial idle rel161", ts0, 1);
        wait_rel(200);

        // 7O2 loopback of 0x55: odd parity bit is 1, frame is 11 bits.
        exp_rx(1, 8'h55, 1'b0, 1'b0, 155);
        exp_done(1, 176);
        pulse_start(1, 8'h55);
        wait_rel(25);
        chk("t2 serial data0", ts1, 1);
        wait_rel(41);
        chk("t2 serial data1", ts1, 0);
        wait_rel(137);
        chk("t2 serial parity", ts1, 1);
        wait_rel(169);
        chk("t2 serial stop2", ts1, 1);
        chk("t2 tx_active stop2", ta1, 1);
        wait_rel(177);
        chk("t2 tx_active rel177", ta1, 0);
        wait_rel(220);

        // 8E1 external: 0x3C with wrong parity, then 0x07 with correct parity.
        exp_rx(2, 8'h3C, 1'b1, 1'b0, -1);
        send_serial(2, {1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        repeat (40) @(negedge clk);
        exp_rx(2, 8'h07, 1'b0, 1'b0, -1);
        send_serial(2, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
        repeat (40) @(negedge clk);

        // 8N1 external: short glitch, then a break-terminated frame, then a good frame.
        l0 = 1'b0;
        r0 = 1'b0;
        repeat (5) @(negedge clk);
        r0 = 1'b1;
        repeat (40) @(negedge clk);
        exp_rx(0, 8'h00, 1'b0, 1'b1, -1);
        send_serial(0, 16'h0000, 12);
        repeat (40) @(negedge clk);
        exp_rx(0, 8'h5A, 1'b0, 1'b0, -1);
        send_serial(0, {1'b1, 8'h5A, 1'b0}, 10);
        repeat (40) @(negedge clk);

        // Tx_Start held for 400 cycles: accepts at 0, 161, 322; byte latched at acceptance.
        l0 = 1'b1;
        exp_rx(0, 8'h11, 1'b0, 1'b0, 155);
        exp_done(0, 160);
        exp_rx(0, 8'h22, 1'b0, 1'b0, 316);
        exp_done(0, 321);
        exp_rx(0, 8'h33, 1'b0, 1'b0, 477);
        exp_done(0, 482);
        b0 = 8'h11;
        s0 = 1'b1;
        t0 = cyc + 1;
        wait_rel(50);
        b0 = 8'h22;
        wait_rel(161);
        chk("t5 gap tx_active", ta0, 0);
        chk("t5 gap serial", ts0, 1);
        wait_rel(162);
        chk("t5 frame1 start", ts0, 0);
        wait_rel(200);
        b0 = 8'h33;
        wait_rel(400);
        s0 = 1'b0;
        wait_rel(420);
        b0 = 8'hEE;
        s0 = 1'b1;
        wait_rel(421);
        s0 = 1'b0;
        wait_rel(483);
        chk("t5 idle after frame2", ta0, 0);
        wait_rel(700);

        // Asynchronous reset in the middle of a loopback frame of 0x00.
        pulse_start(0, 8'h00);
        wait_rel(60);
        chk("t6 serial before reset", ts0, 0);
        rst_n = 1'b0;
        #1;
        chk("t6 reset tx_serial", ts0, 1);
        chk("t6 reset tx_active", ta0, 0);
        chk("t6 reset tx_done", td0, 0);
        chk("t6 reset data_valid", dv0, 0);
        chk("t6 reset rx_byte", rb0, 0);
        chk("t6 reset frame_err", fe0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        exp_rx(0, 8'h81, 1'b0, 1'b0, 155);
        exp_done(0, 160);
        pulse_start(0, 8'h81);
        wait_rel(200);

        n_vec++;
        if (rx_q.size() != 0 || done_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d rx and %0d done pending, required 0 and 0",
                     rx_q.size(), done_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
